// File: rtl/multichannel_sipo_deserializer_if.sv
// Bundle that connects the serial bit stream and the word handshake of the deserializer.
// The master side drives bits and ready. The slave side (the deserializer) returns framed words.
interface multichannel_sipo_deserializer_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 1
);
    logic             enable;
    logic             serial_in;
    logic             frame_sync;
    logic             output_ready;
    logic [WIDTH-1:0] out_word;
    logic [CW-1:0]    out_channel;
    logic             output_valid;
    logic             overrun;
    logic             sync_error;

    modport master (
        output enable, serial_in, frame_sync, output_ready,
        input  out_word, out_channel, output_valid, overrun, sync_error
    );

    modport slave (
        input  enable, serial_in, frame_sync, output_ready,
        output out_word, out_channel, output_valid, overrun, sync_error
    );
endinterface

// File: rtl/multichannel_sipo_deserializer.sv
// Framed serial-to-parallel deserializer that produces WIDTH-bit words for CHANNELS interleaved channels.
// state    | meaning
// ST_HUNT  | waiting for the first frame_sync; incoming bits are dropped
// ST_SHIFT | assembling words; frame_sync realigns to bit 0 of channel 0
module multichannel_sipo_deserializer #(
    parameter int WIDTH        = 8,
    parameter int CHANNELS     = 2,
    parameter int MSB_FIRST    = 0,
    parameter int REQUIRE_SYNC = 1
) (
    input  logic clk,
    input  logic rstn,
    multichannel_sipo_deserializer_if.slave bus
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {ST_HUNT, ST_SHIFT} state_t;

    localparam state_t RESET_STATE = (REQUIRE_SYNC != 0) ? ST_HUNT : ST_SHIFT;

    state_t           state_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [BW-1:0]    bit_cnt_q;
    logic [CW-1:0]    ch_cnt_q;
    logic [WIDTH-1:0] out_q;
    logic [CW-1:0]    out_ch_q;
    logic             valid_q;
    logic             overrun_q;
    logic             sync_err_q;

    always_comb begin
        sr_d = sr_q;
        if (MSB_FIRST != 0) sr_d = {sr_q[WIDTH-2:0], bus.serial_in};
        else                sr_d = {bus.serial_in, sr_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= RESET_STATE;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            ch_cnt_q   <= '0;
            out_q      <= '0;
            out_ch_q   <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            overrun_q  <= 1'b0;
            sync_err_q <= 1'b0;
            if (valid_q && bus.output_ready) valid_q <= 1'b0;
            case (state_q)
                ST_HUNT: begin
                    if (bus.enable && bus.frame_sync) begin
                        sr_q      <= sr_d;
                        bit_cnt_q <= BW'(1);
                        ch_cnt_q  <= '0;
                        state_q   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bus.enable) begin
                        sr_q <= sr_d;
                        // Misaligned sync drops the partial word; stale bits age out before the next completion.
                        if (bus.frame_sync && (bit_cnt_q != '0 || ch_cnt_q != '0)) begin
                            sync_err_q <= 1'b1;
                            bit_cnt_q  <= BW'(1);
                            ch_cnt_q   <= '0;
                        end else if (bit_cnt_q == BW'(WIDTH - 1)) begin
                            out_q     <= sr_d;
                            out_ch_q  <= ch_cnt_q;
                            valid_q   <= 1'b1;
                            overrun_q <= valid_q && !bus.output_ready;
                            bit_cnt_q <= '0;
                            ch_cnt_q  <= (ch_cnt_q == CW'(CHANNELS - 1)) ? '0 : ch_cnt_q + CW'(1);
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                        end
                    end
                end
                default: state_q <= RESET_STATE;
            endcase
        end
    end

    assign bus.out_word     = out_q;
    assign bus.out_channel  = out_ch_q;
    assign bus.output_valid = valid_q;
    assign bus.overrun      = overrun_q;
    assign bus.sync_error   = sync_err_q;
endmodule

// File: tb/tb_multichannel_sipo_deserializer.sv
// Bench that runs LSB-first and MSB-first instances side by side on a shared bit stream.
// Both instances are compared each cycle against a queue-based frame model.
module tb_multichannel_sipo_deserializer;
    localparam int W  = 8;
    localparam int CH = 2;
    localparam int CW = 1;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic en_s = 1'b0, bit_s = 1'b0, fs_s = 1'b0, rdy_s = 1'b0;

    multichannel_sipo_deserializer_if #(.WIDTH(W), .CW(CW)) if_l ();
    multichannel_sipo_deserializer_if #(.WIDTH(W), .CW(CW)) if_m ();

    assign if_l.enable = en_s;  assign if_l.serial_in = bit_s;
    assign if_l.frame_sync = fs_s;  assign if_l.output_ready = rdy_s;
    assign if_m.enable = en_s;  assign if_m.serial_in = bit_s;
    assign if_m.frame_sync = fs_s;  assign if_m.output_ready = rdy_s;

    multichannel_sipo_deserializer #(.WIDTH(W), .CHANNELS(CH), .MSB_FIRST(0), .REQUIRE_SYNC(1))
        dut_l (.clk(clk), .rstn(rstn), .bus(if_l.slave));
    multichannel_sipo_deserializer #(.WIDTH(W), .CHANNELS(CH), .MSB_FIRST(1), .REQUIRE_SYNC(1))
        dut_m (.clk(clk), .rstn(rstn), .bus(if_m.slave));

    int n_cmp = 0;
    int n_mis = 0;

    // Frame model: bits gathered in arrival order, words built when the queue holds W bits.
    bit         q[$];
    bit         m_sync;
    int         m_ch, m_och;
    logic [W-1:0] m_out_l, m_out_m;
    bit         m_valid, m_ovr, m_serr;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_sync = 1'b0; m_ch = 0; m_och = 0;
        m_out_l = '0; m_out_m = '0;
        m_valid = 1'b0; m_ovr = 1'b0; m_serr = 1'b0;
    endtask

    task automatic model_edge(input bit en, input bit b, input bit fs, input bit rdy);
        bit prev_valid;
        prev_valid = m_valid;
        m_ovr = 1'b0; m_serr = 1'b0;
        if (m_valid && rdy) m_valid = 1'b0;
        if (en) begin
            if (!m_sync) begin
                if (fs) begin m_sync = 1'b1; q.delete(); q.push_back(b); m_ch = 0; end
            end else if (fs && (q.size() != 0 || m_ch != 0)) begin
                m_serr = 1'b1; q.delete(); q.push_back(b); m_ch = 0;
            end else begin
                q.push_back(b);
                if (q.size() == W) begin
                    for (int i = 0; i < W; i++) begin
                        m_out_l[i] = q[i];
                        m_out_m[W-1-i] = q[i];
                    end
                    m_och = m_ch;
                    m_ovr = prev_valid && !rdy;
                    m_valid = 1'b1;
                    m_ch = (m_ch + 1) % CH;
                    q.delete();
                end
            end
        end
    endtask

    task automatic check_all(input string ph);
        check_val({ph, ".out_l"}, 32'(if_l.out_word), 32'(m_out_l));
        check_val({ph, ".out_m"}, 32'(if_m.out_word), 32'(m_out_m));
        check_val({ph, ".ch_l"}, 32'(if_l.out_channel), 32'(m_och));
        check_val({ph, ".ch_m"}, 32'(if_m.out_channel), 32'(m_och));
        check_val({ph, ".valid_l"}, 32'(if_l.output_valid), 32'(m_valid));
        check_val({ph, ".valid_m"}, 32'(if_m.output_valid), 32'(m_valid));
        check_val({ph, ".ovr_l"}, 32'(if_l.overrun), 32'(m_ovr));
        check_val({ph, ".ovr_m"}, 32'(if_m.overrun), 32'(m_ovr));
        check_val({ph, ".serr_l"}, 32'(if_l.sync_error), 32'(m_serr));
        check_val({ph, ".serr_m"}, 32'(if_m.sync_error), 32'(m_serr));
    endtask

    task automatic step(input bit en, input bit b, input bit fs, input bit rdy, input string ph);
        en_s = en; bit_s = b; fs_s = fs; rdy_s = rdy;
        model_edge(en, b, fs, rdy);
        @(posedge clk);
        #1;
        check_all(ph);
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit fs, input bit rdy, input string ph);
        for (int i = 0; i < W; i++) step(1'b1, w[i], fs && (i == 0), rdy, ph);
    endtask

    initial begin
        logic [W-1:0] w;
        model_reset();
        #1;
        check_all("reset");
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Hunting: bits without frame_sync are dropped.
        for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom), 1'b0, 1'b1, "t1_hunt");
        check_val("t1_valid", 32'(if_l.output_valid), 32'd0);

        // Aligned words in both bit orders with channel tagging.
        send_word(8'h96, 1'b1, 1'b1, "t2");
        check_val("t2_w0_l", 32'(if_l.out_word), 32'h96);
        check_val("t2_w0_m", 32'(if_m.out_word), 32'h69);
        check_val("t2_w0_ch", 32'(if_l.out_channel), 32'd0);
        send_word(8'hC9, 1'b0, 1'b1, "t2");
        check_val("t2_w1_l", 32'(if_l.out_word), 32'hC9);
        check_val("t2_w1_m", 32'(if_m.out_word), 32'h93);
        check_val("t2_w1_ch", 32'(if_l.out_channel), 32'd1);
        send_word(8'h5A, 1'b0, 1'b1, "t2");
        check_val("t2_w2_ch", 32'(if_l.out_channel), 32'd0);

        // Overrun with consumer stalled.
        send_word(8'h11, 1'b0, 1'b1, "t3_fill");
        send_word(8'h96, 1'b1, 1'b0, "t3");
        send_word(8'hC9, 1'b0, 1'b0, "t3");
        check_val("t3_out", 32'(if_l.out_word), 32'hC9);
        check_val("t3_ch", 32'(if_l.out_channel), 32'd1);
        check_val("t3_ovr", 32'(if_l.overrun), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, "t3_hold");
        check_val("t3_ovr_pulse", 32'(if_l.overrun), 32'd0);
        check_val("t3_valid_hold", 32'(if_l.output_valid), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, "t3_accept");
        check_val("t3_valid_drop", 32'(if_l.output_valid), 32'd0);

        // Enable gaps in mid-word with the data and sync lines toggling.
        w = 8'h36;
        for (int i = 0; i < 4; i++) step(1'b1, w[i], i == 0, 1'b1, "t4");
        for (int i = 0; i < 3; i++) step(1'b0, 1'(i), 1'(i == 1), 1'b1, "t4_gap");
        for (int i = 4; i < W; i++) step(1'b1, w[i], 1'b0, 1'b1, "t4");
        check_val("t4_out", 32'(if_l.out_word), 32'h36);
        send_word(8'hE7, 1'b0, 1'b1, "t4_fill");

        // Mid-word frame_sync.
        w = 8'hA5;
        for (int i = 0; i < 5; i++) step(1'b1, w[i], i == 0, 1'b1, "t5_part");
        w = 8'hC9;
        for (int i = 0; i < W; i++) begin
            step(1'b1, w[i], i == 0, 1'b1, "t5");
            if (i == 0) check_val("t5_serr", 32'(if_l.sync_error), 32'd1);
            if (i == 1) check_val("t5_serr_pulse", 32'(if_l.sync_error), 32'd0);
        end
        check_val("t5_out", 32'(if_l.out_word), 32'hC9);
        check_val("t5_ch", 32'(if_l.out_channel), 32'd0);

        // Asynchronous reset mid-word while a word is pending.
        send_word(8'h3C, 1'b0, 1'b0, "t6_pend");
        for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0, "t6_part");
        #2 rstn = 1'b0;
        #1;
        model_reset();
        check_all("t6_async");
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 12; i++) step(1'b1, 1'($urandom), 1'b0, 1'b1, "t6_hunt");
        send_word(8'h81, 1'b1, 1'b1, "t6_resync");
        check_val("t6_out", 32'(if_l.out_word), 32'h81);

        // Random traffic.
        for (int i = 0; i < 1500; i++)
            step(($urandom % 4) != 0, 1'($urandom), ($urandom % 37) == 0,
                 ($urandom % 3) != 0, "rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
